// File: rtl/cpu_pkg.sv
// Shared core definitions: next-PC source codes, IR field positions,
// fetch FSM states and opcode constants used by fetch and control.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    PCS_INC  = 2'd0,
    PCS_REG  = 2'd1,
    PCS_DISP = 2'd2,
    PCS_HOLD = 2'd3
  } pcsrc_e;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fstate_e;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int EXT_HI = 7;
  localparam int EXT_LO = 4;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 0;
  localparam int IMM_HI = 7;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_SPEC  = 4'h4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and imem.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) ();
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit_pc_next_mux.sv
// Next-PC select: increment, register target, sign-extended displacement.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  pcsrc_e            i_src,
  input  logic [ADDR_W-1:0] i_jump,
  input  logic [7:0]        i_imm8,
  output logic [ADDR_W-1:0] o_next,
  output logic [ADDR_W-1:0] o_pc_plus1
);

  logic [ADDR_W-1:0] w_disp;

  assign w_disp     = {{(ADDR_W-8){i_imm8[7]}}, i_imm8};
  assign o_pc_plus1 = i_pc + 1'b1;

  always_comb begin
    o_next = i_pc;
    unique case (i_src)
      PCS_INC:  o_next = o_pc_plus1;
      PCS_REG:  o_next = i_jump;
      PCS_DISP: o_next = i_pc + w_disp;
      PCS_HOLD: o_next = i_pc;
      default:  o_next = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, IR, imem req/ack FSM and IR field split.
// Optional FETCH_RETIRE_COUNT_EN builds a retired-instruction counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               InstrWrite,
  input  logic               PCWrite,
  input  logic [1:0]         PCSource,
  input  logic [ADDR_W-1:0]  JumpTarget,
  fetch_unit_if.master       imem,
  output logic               FetchBusy,
  output logic [INSTR_W-1:0] Instr,
  output logic [3:0]         OPCode,
  output logic [3:0]         RdestIdx,
  output logic [3:0]         JCond,
  output logic [3:0]         cond,
  output logic [3:0]         OPCodeExtension,
  output logic [3:0]         RsrcIdx,
  output logic [7:0]         Imm8,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  PCPlus1,
  output logic               ProtoErr,
  output logic [31:0]        RetiredCount
);

  fstate_e            r_state;
  fstate_e            w_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_ir;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_perr;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_req;
  logic               w_pcw_ok;

  always_ff @(posedge Clk) begin
    if (reset) r_state <= F_IDLE;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    unique case (r_state)
      F_IDLE:  if (InstrWrite)    w_state = F_REQ;
      F_REQ:   if (imem.imem_ack) w_state = F_IDLE;
      default: w_state = F_IDLE;
    endcase
  end

  always_comb begin
    w_req = (r_state == F_REQ);
  end

  assign w_pcw_ok = PCWrite && (r_state == F_IDLE);

  pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
    .i_pc       (r_pc),
    .i_src      (pcsrc_e'(PCSource)),
    .i_jump     (JumpTarget),
    .i_imm8     (r_ir[IMM_HI:0]),
    .o_next     (w_pc_next),
    .o_pc_plus1 (PCPlus1)
  );

  // fetch address is captured from the pre-update PC
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_addr <= RESET_PC;
      r_ir   <= '0;
      r_pc   <= RESET_PC;
      r_perr <= 1'b0;
    end else begin
      if (r_state == F_IDLE && InstrWrite) r_addr <= r_pc;
      if (r_state == F_REQ && imem.imem_ack) r_ir <= imem.imem_rdata;
      if (w_pcw_ok) r_pc <= w_pc_next;
      if ((PCWrite && r_state == F_REQ) ||
          (imem.imem_ack && r_state == F_IDLE))
        r_perr <= 1'b1;
    end
  end

`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] r_retired;
  always_ff @(posedge Clk) begin
    if (reset)         r_retired <= '0;
    else if (w_pcw_ok) r_retired <= r_retired + 32'd1;
  end
  assign RetiredCount = r_retired;
`else
  assign RetiredCount = 32'd0;
`endif

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_addr;
  assign FetchBusy      = w_req;
  assign Instr          = r_ir;
  assign OPCode          = r_ir[OPC_HI:OPC_LO];
  assign RdestIdx        = r_ir[RD_HI:RD_LO];
  assign JCond           = r_ir[RD_HI:RD_LO];
  assign cond            = r_ir[RD_HI:RD_LO];
  assign OPCodeExtension = r_ir[EXT_HI:EXT_LO];
  assign RsrcIdx         = r_ir[RS_HI:RS_LO];
  assign Imm8            = r_ir[IMM_HI:0];
  assign PC              = r_pc;
  assign ProtoErr        = r_perr;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the multicycle CR16-style core: owns the PC and the instruction register (IR).
- Fetches from instruction memory over a req/ack handshake when the control FSM asserts InstrWrite.
- Splits the IR into the OPCode/OPCodeExtension/JCond/cond/register/immediate fields that the control FSM and datapath consume.
- Applies next-PC selection (PC+1, register target, PC-relative displacement) on PCWrite.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width (word addressed).
- INSTR_W, 16, instruction width; field positions below assume 16.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- Clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- InstrWrite  input  1  control FSM in IFETCH: start fetch at current PC
- PCWrite  input  1  update PC this cycle
- PCSource  input  2  0=PC+1, 1=JumpTarget, 2=PC+sext(Disp), 3=hold
- JumpTarget  input  ADDR_W  register-file value (Rsrc) for Jcond/JAL/RETX
- imem_req  output  1  fetch request, held until ack
- imem_addr  output  ADDR_W  fetch address (latched PC)
- imem_rdata  input  INSTR_W  instruction word, valid with imem_ack
- imem_ack  input  1  one-cycle completion strobe
- FetchBusy  output  1  fetch outstanding; control holds IFETCH while high
- Instr  output  INSTR_W  IR contents
- OPCode  output  4  Instr[15:12]
- RdestIdx  output  4  Instr[11:8]
- JCond  output  4  Instr[11:8] (Jcond condition field)
- cond  output  4  Instr[11:8] (Bcond/Scond condition field)
- OPCodeExtension  output  4  Instr[7:4]
- RsrcIdx  output  4  Instr[3:0]
- Imm8  output  8  Instr[7:0]
- PC  output  ADDR_W  current PC
- PCPlus1  output  ADDR_W  PC+1, JAL link value
- ProtoErr  output  1  sticky protocol-violation flag
- RetiredCount  output  32  instructions retired (optional feature)

Behaviour:
- Reset (synchronous, active-high): PC=RESET_PC, IR=16'h0000 (decodes to NOP), FSM=F_IDLE, imem_req=0, FetchBusy=0, ProtoErr=0, RetiredCount=0. Reset wins over every other input in the same cycle. Reset during F_REQ drops imem_req the next cycle; a later ack is ignored.
- FSM states: F_IDLE, F_REQ.
- F_IDLE with InstrWrite=1: latch imem_addr<=PC, go to F_REQ. imem_req and FetchBusy rise the next cycle.
- F_REQ: imem_req=1 and FetchBusy=1, addr stable. On imem_ack: IR<=imem_rdata and return to F_IDLE. imem_req and FetchBusy are 0 in the cycle after the ack. Minimum fetch latency: InstrWrite at cycle n, IR valid at n+2 (zero-wait ack at n+1).
- InstrWrite while in F_REQ is ignored (no re-issue).
- imem_ack in F_IDLE is ignored, and sets ProtoErr.
- Decode outputs are combinational from IR and hold until the next ack.
- PCWrite, honoured in F_IDLE only:
  - src 0: PC+1
  - src 1: JumpTarget
  - src 2: PC + sign-extend(Imm8) to ADDR_W
  - src 3: PC unchanged
- All PC arithmetic is modulo 2^ADDR_W; wrap from FFFF to 0000 is silent.
- PCWrite while FetchBusy=1: ignored, PC held, ProtoErr set.
- PCWrite and InstrWrite in the same F_IDLE cycle: fetch uses the old PC, then PC updates.
- PCPlus1 is combinational PC+1, also modulo 2^ADDR_W.

Optional Feature:
- Macro FETCH_RETIRE_COUNT_EN.
- Defined: 32-bit RetiredCount increments on every honoured PCWrite (any PCSource) and wraps at 2^32.
- Undefined: RetiredCount is tied to 0 and no counter flops are built.

Decomposition:
- Shared package cpu_pkg: PCSource encodings (PCS_INC, PCS_REG, PCS_DISP, PCS_HOLD), IR field bit positions, fetch FSM state encodings, opcode constants shared with the control FSM.
- One natural sub-module: pc_next_mux (combinational next-PC select plus displacement sign extension), instantiated once.

Test Plan:
- Reset, then InstrWrite with ack on the next cycle returning 16'h5123 -> imem_addr=0000. IR=5123 at cycle 2 after InstrWrite. OPCode=5, RdestIdx=1, OPCodeExtension=2, RsrcIdx=3.
- Ack delayed 3 cycles, InstrWrite re-pulsed mid-wait -> imem_req high exactly 4 cycles, a single fetch, FetchBusy tracks imem_req.
- PC=0010, PCWrite with src 2 and Imm8=F0 -> PC=0000. PC=0010, src 2, Imm8=7F -> PC=008F.
- PC=FFFF, PCWrite with src 0 -> PC=0000, PCPlus1=0001. Then src 1 with JumpTarget=1234 -> PC=1234.
- PCWrite during F_REQ -> PC unchanged, ProtoErr=1 and stays 1 until reset.
- Reset asserted mid-F_REQ, then ack arrives -> imem_req=0 after reset, IR stays 0000. With FETCH_RETIRE_COUNT_EN: 5 PCWrites -> RetiredCount=5.
